// File: rtl/toy_bus_ack_crd_arb.sv
// Credit-flowed 2:1 round-robin arbiter for ToyBusAck messages with a registered output stage.
// Optional stall counter enabled by defining TOY_BUS_ACK_CRD_ARB_PERF_EN.
module toy_bus_ack_crd_arb #(
   parameter int CREDIT_MAX = 4,
   parameter int CRD_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             in0_vld,
   output logic             in0_rdy,
   input  logic             in0_opcode,
   input  logic [255:0]     in0_data,
   input  logic [31:0]      in0_sideband,
   input  logic [3:0]       in0_src_id,
   input  logic [3:0]       in0_tgt_id,

   input  logic             in1_vld,
   output logic             in1_rdy,
   input  logic             in1_opcode,
   input  logic [255:0]     in1_data,
   input  logic [31:0]      in1_sideband,
   input  logic [3:0]       in1_src_id,
   input  logic [3:0]       in1_tgt_id,

   output logic             out0_vld,
   output logic             out0_opcode,
   output logic [255:0]     out0_data,
   output logic [31:0]      out0_sideband,
   output logic [3:0]       out0_src_id,
   output logic [3:0]       out0_tgt_id,
   input  logic             out0_crd_rtn,

`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
   input  logic             stall_clr,
   output logic [15:0]      stall_cnt,
`endif

   output logic [CRD_W-1:0] crd_cnt,
   output logic             crd_err
);

   localparam int PL_W = 1 + 256 + 32 + 4 + 4;
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDIT_MAX);

   logic [1:0]      req_vld;
   logic [1:0]      gnt;
   logic [1:0]      rdy;
   logic [PL_W-1:0] req_pl [2];

   logic            prio_q, prio_d;
   logic [CRD_W-1:0] crd_cnt_q, crd_cnt_d;
   logic            crd_err_q, crd_err_d;
   logic            out_vld_q, out_vld_d;
   logic [PL_W-1:0] out_pl_q, out_pl_d;

   logic            can_send;
   logic            fire;
   logic            win;

   assign req_vld   = {in1_vld, in0_vld};
   assign req_pl[0] = {in0_opcode, in0_data, in0_sideband, in0_src_id, in0_tgt_id};
   assign req_pl[1] = {in1_opcode, in1_data, in1_sideband, in1_src_id, in1_tgt_id};

   assign can_send = (crd_cnt_q != '0);

   // An input wins when it is the sole requester or when it holds priority on a tie.
   assign gnt[0] = req_vld[0] & (~req_vld[1] | ~prio_q);
   assign gnt[1] = req_vld[1] & (~req_vld[0] |  prio_q);

   // rst_n gating keeps rdy low during reset even though the count already reads full.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rdy
         assign rdy[gi] = gnt[gi] & can_send & rst_n;
      end
   endgenerate

   assign in0_rdy = rdy[0];
   assign in1_rdy = rdy[1];

   assign fire = rdy[0] | rdy[1];
   assign win  = rdy[1];

   always_comb begin
      prio_d    = prio_q;
      out_vld_d = fire;
      out_pl_d  = out_pl_q;
      crd_cnt_d = crd_cnt_q;
      crd_err_d = crd_err_q;

      if (fire) begin
         prio_d   = ~win;
         out_pl_d = req_pl[win];
      end

      if (fire && !out0_crd_rtn) begin
         crd_cnt_d = crd_cnt_q - 1'b1;
      end else if (!fire && out0_crd_rtn) begin
         if (crd_cnt_q == CRD_FULL) begin
            crd_err_d = 1'b1;
         end else begin
            crd_cnt_d = crd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q    <= 1'b0;
         out_vld_q <= 1'b0;
         out_pl_q  <= '0;
         crd_cnt_q <= CRD_FULL;
         crd_err_q <= 1'b0;
      end else begin
         prio_q    <= prio_d;
         out_vld_q <= out_vld_d;
         out_pl_q  <= out_pl_d;
         crd_cnt_q <= crd_cnt_d;
         crd_err_q <= crd_err_d;
      end
   end

   assign out0_vld      = out_vld_q;
   assign out0_opcode   = out_pl_q[296];
   assign out0_data     = out_pl_q[295:40];
   assign out0_sideband = out_pl_q[39:8];
   assign out0_src_id   = out_pl_q[7:4];
   assign out0_tgt_id   = out_pl_q[3:0];
   assign crd_cnt       = crd_cnt_q;
   assign crd_err       = crd_err_q;

`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if ((|req_vld) && !can_send && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_toy_bus_ack_crd_arb.sv
// Directed self-checking bench for toy_bus_ack_crd_arb.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_toy_bus_ack_crd_arb;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in0_vld, in0_rdy, in0_opcode;
   logic [255:0] in0_data;
   logic [31:0]  in0_sideband;
   logic [3:0]   in0_src_id, in0_tgt_id;
   logic         in1_vld, in1_rdy, in1_opcode;
   logic [255:0] in1_data;
   logic [31:0]  in1_sideband;
   logic [3:0]   in1_src_id, in1_tgt_id;
   logic         out0_vld, out0_opcode;
   logic [255:0] out0_data;
   logic [31:0]  out0_sideband;
   logic [3:0]   out0_src_id, out0_tgt_id;
   logic         out0_crd_rtn;
   logic [3:0]   crd_cnt;
   logic         crd_err;
`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
   logic         stall_clr;
   logic [15:0]  stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   toy_bus_ack_crd_arb #(.CREDIT_MAX(4), .CRD_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_opcode(in0_opcode), .in0_data(in0_data),
      .in0_sideband(in0_sideband), .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
      .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_opcode(in1_opcode), .in1_data(in1_data),
      .in1_sideband(in1_sideband), .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id),
      .out0_vld(out0_vld), .out0_opcode(out0_opcode), .out0_data(out0_data),
      .out0_sideband(out0_sideband), .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
      .out0_crd_rtn(out0_crd_rtn),
`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
      .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
      .crd_cnt(crd_cnt), .crd_err(crd_err)
   );

   task automatic cyc(input logic v0, input logic v1, input logic rtn);
      @(posedge clk); #1;
      in0_vld = v0; in1_vld = v1; out0_crd_rtn = rtn;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0; out0_crd_rtn = 1'b0;
`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
      stall_clr = 1'b0;
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in0_vld = 1'b1; in1_vld = 1'b1; out0_crd_rtn = 1'b0;
      @(negedge clk);
      checks++; if (in0_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy0 got %b want 0", in0_rdy); end
      checks++; if (in1_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy1 got %b want 0", in1_rdy); end
      checks++; if (out0_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", out0_vld); end
      checks++; if (crd_cnt !== 4'd4) begin errors++; $display("FAIL reset_crd got %0d want 4", crd_cnt); end
      checks++; if (crd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", crd_err); end
      checks++; if (out0_data !== 256'd0 || out0_src_id !== 4'd0) begin errors++; $display("FAIL reset_payload got %h/%h want 0", out0_data, out0_src_id); end
      $display("reset: rdy=%b%b vld=%b crd=%0d err=%b", in1_rdy, in0_rdy, out0_vld, crd_cnt, crd_err);
      do_reset();
   endtask

   task automatic test_fill();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         checks++; if (in0_rdy !== (k < 4)) begin errors++; $display("FAIL fill_rdy%0d got %b want %b", k, in0_rdy, (k < 4)); end
         checks++; if (crd_cnt !== ((k <= 4) ? 4'(4 - k) : 4'd0)) begin errors++; $display("FAIL fill_crd%0d got %0d", k, crd_cnt); end
         checks++; if (out0_vld !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL fill_vld%0d got %b", k, out0_vld); end
         if (k == 1) begin
            checks++; if (out0_data !== {32{8'hA5}} || out0_opcode !== 1'b1 || out0_src_id !== 4'hA) begin
               errors++; $display("FAIL fill_payload got %h op %b src %h want a5.. 1 a", out0_data, out0_opcode, out0_src_id); end
         end
         $display("fill cyc %0d: rdy0=%b vld=%b crd=%0d", k, in0_rdy, out0_vld, crd_cnt);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 1'b1, k >= 1);
         checks++; if (in0_rdy !== (k % 2 == 0) || in1_rdy !== (k % 2 == 1)) begin
            errors++; $display("FAIL alt_gnt%0d got %b%b want %b%b", k, in1_rdy, in0_rdy, (k % 2 == 1), (k % 2 == 0)); end
         checks++; if (crd_cnt !== ((k == 0) ? 4'd4 : 4'd3)) begin errors++; $display("FAIL alt_crd%0d got %0d", k, crd_cnt); end
         if (k >= 1) begin
            checks++; if (out0_vld !== 1'b1 || out0_src_id !== (((k - 1) % 2 == 0) ? 4'hA : 4'h5)) begin
               errors++; $display("FAIL alt_out%0d got vld %b src %h", k, out0_vld, out0_src_id); end
         end
         $display("alt cyc %0d: rdy=%b%b src=%h crd=%0d", k, in1_rdy, in0_rdy, out0_src_id, crd_cnt);
      end
   endtask

   task automatic test_zero_credit();
      do_reset();
      repeat (4) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if ({in1_rdy, in0_rdy} !== 2'b00 || crd_cnt !== 4'd0) begin errors++; $display("FAIL zc_idle got rdy %b%b crd %0d want 00 0", in1_rdy, in0_rdy, crd_cnt); end
      cyc(1'b1, 1'b1, 1'b1);
      checks++; if ({in1_rdy, in0_rdy} !== 2'b00) begin errors++; $display("FAIL zc_rtn_cyc got rdy %b%b want 00", in1_rdy, in0_rdy); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if ({in1_rdy, in0_rdy} !== 2'b10 || crd_cnt !== 4'd1) begin errors++; $display("FAIL zc_fire got rdy %b%b crd %0d want 10 1", in1_rdy, in0_rdy, crd_cnt); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if ({in1_rdy, in0_rdy} !== 2'b00 || crd_cnt !== 4'd0 || out0_vld !== 1'b1 || out0_src_id !== 4'h5) begin
         errors++; $display("FAIL zc_after got rdy %b%b crd %0d vld %b src %h want 00 0 1 5", in1_rdy, in0_rdy, crd_cnt, out0_vld, out0_src_id); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (out0_vld !== 1'b0 || crd_cnt !== 4'd0) begin errors++; $display("FAIL zc_end got vld %b crd %0d want 0 0", out0_vld, crd_cnt); end
      $display("zero credit: single fire by in1, crd=%0d", crd_cnt);
   endtask

   task automatic test_fire_rtn();
      do_reset();
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      checks++; if (crd_cnt !== 4'd2 || in0_rdy !== 1'b1) begin errors++; $display("FAIL fr_pre got crd %0d rdy %b want 2 1", crd_cnt, in0_rdy); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (crd_cnt !== 4'd2 || out0_vld !== 1'b1) begin errors++; $display("FAIL fr_post got crd %0d vld %b want 2 1", crd_cnt, out0_vld); end
      $display("fire+return: crd=%0d vld=%b", crd_cnt, out0_vld);
   endtask

   task automatic test_crd_err();
      do_reset();
      cyc(1'b0, 1'b0, 1'b1);
      checks++; if (crd_err !== 1'b0 || crd_cnt !== 4'd4) begin errors++; $display("FAIL err_pre got err %b crd %0d want 0 4", crd_err, crd_cnt); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (crd_err !== 1'b1 || crd_cnt !== 4'd4) begin errors++; $display("FAIL err_set got err %b crd %0d want 1 4", crd_err, crd_cnt); end
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      checks++; if (crd_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", crd_err); end
      do_reset();
      @(negedge clk);
      checks++; if (crd_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", crd_err); end
      $display("crd_err: sticky then cleared by reset, err=%b", crd_err);
   endtask

   task automatic test_mid_reset();
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (out0_vld !== 1'b1 || crd_cnt !== 4'd3) begin errors++; $display("FAIL mr_pre got vld %b crd %0d want 1 3", out0_vld, crd_cnt); end
      rst_n = 1'b0;
      #1;
      checks++; if (out0_vld !== 1'b0 || crd_cnt !== 4'd4 || out0_data !== 256'd0 || in0_rdy !== 1'b0) begin
         errors++; $display("FAIL mr_async got vld %b crd %0d rdy %b want 0 4 0", out0_vld, crd_cnt, in0_rdy); end
      $display("mid reset: vld=%b crd=%0d", out0_vld, crd_cnt);
      do_reset();
   endtask

`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      repeat (4) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL perf_zero got %0d want 0", stall_cnt); end
      repeat (10) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL perf_ten got %0d want 10", stall_cnt); end
      @(posedge clk); #1;
      stall_clr = 1'b1; in1_vld = 1'b1;
      @(posedge clk); #1;
      stall_clr = 1'b0; in1_vld = 1'b0;
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL perf_clr got %0d want 0", stall_cnt); end
      repeat (2) cyc(1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if (stall_cnt !== 16'd0 || crd_cnt !== 4'd4 || out0_vld !== 1'b0) begin
         errors++; $display("FAIL perf_rst got stall %0d crd %0d vld %b want 0 4 0", stall_cnt, crd_cnt, out0_vld); end
      $display("perf: stall counter checked");
      do_reset();
   endtask
`endif

   initial begin
      in0_opcode = 1'b1; in0_data = {32{8'hA5}}; in0_sideband = 32'h1111_0000; in0_src_id = 4'hA; in0_tgt_id = 4'h1;
      in1_opcode = 1'b0; in1_data = {32{8'h5A}}; in1_sideband = 32'h2222_0000; in1_src_id = 4'h5; in1_tgt_id = 4'h2;
`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
      stall_clr = 1'b0;
`endif
      test_reset();
      test_fill();
      test_alternate();
      test_zero_credit();
      test_fire_rtn();
      test_crd_err();
      test_mid_reset();
`ifdef TOY_BUS_ACK_CRD_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
